edge_event_recorder: RTL and testbench

- Synchronous monitor that watches a single-bit DUT signal and records every level change as a timestamped event in an on-chip buffer.
- Events are drained through a valid/ready reader port.
- It is the reading and recording end of the single-bit stimulus/response path used by the coverage-callback benches. Bench code and coverage collectors consume its records instead of printing on every transition.

---
 rtl/edge_event_pkg.sv | 19 +
 rtl/evt_fifo.sv | 78 +++++++
 rtl/edge_event_recorder.sv | 112 +++++++++++
 tb/tb_edge_event_recorder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_pkg.sv
// ---------------------------------------------------------------------------
// edge_event_pkg
//   Shared types and default constants for the edge event recorder.
//   edge_rec_t is the record layout at the default timestamp width. The
//   recorder builds the same layout at its own TS_W and hands that type to
//   the FIFO.
// ---------------------------------------------------------------------------
package edge_event_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DROP_W = 8;

    typedef struct packed {
        logic                level;
        logic [DEF_TS_W-1:0] ts;
    } edge_rec_t;

endpackage : edge_event_pkg

// File: rtl/evt_fifo.sv
// ---------------------------------------------------------------------------
// evt_fifo
//   Synchronous FIFO of event records with first-word-fall-through head.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     push_i / din_i   write request and record; ignored when full unless
//                      a pop happens in the same cycle
//     pop_i            read request; ignored when empty
//     full_o, empty_o  fill flags
//     count_o          records currently stored (0..DEPTH)
//     head_o           oldest record (valid when !empty_o)
// ---------------------------------------------------------------------------
module evt_fifo
    import edge_event_pkg::*;
#(
    parameter int   DEPTH = DEF_DEPTH,
    parameter type  rec_t = edge_rec_t,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  rec_t        din_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o,
    output rec_t        head_o
);

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer targets, so the push can be accepted.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; only pointers/count are, since an entry is
    // never read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule : evt_fifo

// File: rtl/edge_event_recorder.sv
// ---------------------------------------------------------------------------
// edge_event_recorder
//   Watches a single-bit signal and records each level change, while
//   enabled, as {new level, timestamp} in a FIFO drained through a
//   valid/ready port. Events arriving while the buffer is full are dropped
//   and accounted in a sticky flag and a saturating counter.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     sample                monitored signal (already synchronous to clk)
//     enable                record edges when 1; level is tracked always
//     rec_valid/rec_ready   reader handshake for the head record
//     rec_level, rec_ts     head record, or last popped record when empty
//     count                 records buffered
//     overflow, drop_cnt    sticky drop flag, saturating drop counter
//     clear_ovf             synchronous clear of overflow/drop_cnt
// ---------------------------------------------------------------------------
module edge_event_recorder
    import edge_event_pkg::*;
#(
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  TS_W   = DEF_TS_W,
    parameter int  DROP_W = DEF_DROP_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample,
    input  logic              enable,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic              rec_level,
    output logic [TS_W-1:0]   rec_ts,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clear_ovf
);

    typedef struct packed {
        logic            level;
        logic [TS_W-1:0] ts;
    } rec_t;

    logic [TS_W-1:0]   ts_q;
    logic              prev_q;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    rec_t              last_q;
    rec_t              head;
    logic              fifo_full, fifo_empty;
    logic              edge_evt, pop, drop;

    assign edge_evt  = enable && (sample != prev_q);
    assign rec_valid = !fifo_empty;
    assign pop       = rec_valid && rec_ready;
    assign drop      = edge_evt && fifo_full && !pop;

    evt_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (edge_evt),
        .din_i   ('{level: sample, ts: ts_q}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count),
        .head_o  (head)
    );

    // A drop in the same cycle as clear_ovf wins: the cleared counter
    // restarts at one.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (clear_ovf)  drop_d = DROP_W'(1);
            else if (!(&drop_q)) drop_d = drop_q + DROP_W'(1);
        end else if (clear_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // NOTE: every register here updates with non-blocking assignments so all
    // of them see the same pre-edge values of prev_q/ts_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            prev_q <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
            last_q <= '0;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            prev_q <= sample;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            if (pop) last_q <= head;
        end
    end

    // With nothing buffered, present the most recently consumed record.
    assign rec_level = rec_valid ? head.level : last_q.level;
    assign rec_ts    = rec_valid ? head.ts    : last_q.ts;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule : edge_event_recorder

// File: tb/tb_edge_event_recorder.sv
// ---------------------------------------------------------------------------
// tb_edge_event_recorder
//   Directed bench. Instance A uses default parameters; instance B uses a
//   4-bit timestamp to exercise wrap. Inputs change 1 time unit after the
//   rising edge and outputs are checked there too, so cycle N (the N-th
//   edge after reset release) carries timestamp N.
// ---------------------------------------------------------------------------
module tb_edge_event_recorder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_sample = 1'b0, a_enable = 1'b1, a_ready = 1'b0, a_clear = 1'b0;
    logic        a_valid, a_level, a_ovf;
    logic [15:0] a_ts;
    logic [3:0]  a_count;
    logic [7:0]  a_drop;

    logic        b_sample = 1'b0, b_enable = 1'b1, b_ready = 1'b0, b_clear = 1'b0;
    logic        b_valid, b_level, b_ovf;
    logic [3:0]  b_ts;
    logic [3:0]  b_count;
    logic [7:0]  b_drop;

    int cyc;
    int n_checks = 0;
    int n_errors = 0;
    int exp_lvl[$];
    int exp_ts[$];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    edge_event_recorder u_dut_a (
        .clk(clk), .rst_n(rst_n), .sample(a_sample), .enable(a_enable),
        .rec_valid(a_valid), .rec_ready(a_ready), .rec_level(a_level),
        .rec_ts(a_ts), .count(a_count), .overflow(a_ovf),
        .drop_cnt(a_drop), .clear_ovf(a_clear)
    );

    edge_event_recorder #(.TS_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sample(b_sample), .enable(b_enable),
        .rec_valid(b_valid), .rec_ready(b_ready), .rec_level(b_level),
        .rec_ts(b_ts), .count(b_count), .overflow(b_ovf),
        .drop_cnt(b_drop), .clear_ovf(b_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            tick();
            guard++;
        end
        check("wait_cyc", cyc, n);
    endtask

    // Toggle A's input in the current cycle, expecting the edge to be stored.
    task automatic toggle_rec();
        a_sample = ~a_sample;
        exp_lvl.push_back(int'(a_sample));
        exp_ts.push_back(cyc);
        tick();
    endtask

    // Toggle A's input in the current cycle, expecting the edge to be dropped.
    task automatic toggle_drop();
        a_sample = ~a_sample;
        tick();
    endtask

    task automatic drain_check(input int n);
        a_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", a_valid, 1);
            check("drain_level", a_level, exp_lvl.pop_front());
            check("drain_ts",    a_ts,    exp_ts.pop_front());
            tick();
        end
        a_ready = 1'b0;
        check("drain_count", a_count, 0);
        check("drain_empty", a_valid, 0);
    endtask

    initial begin
        #22 rst_n = 1'b1;                     // release mid-cycle: cycle 0
        check("rst_valid", a_valid, 0);
        check("rst_level", a_level, 0);
        check("rst_ts",    a_ts,    0);
        check("rst_count", a_count, 0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_drop",  a_drop,  0);

        // 1: single edge in cycle 5, reader always ready
        a_ready = 1'b1;
        wait_cyc(5);
        a_sample = 1'b1;
        check("t1_not_yet", a_valid, 0);
        tick();
        check("t1_valid", a_valid, 1);
        check("t1_level", a_level, 1);
        check("t1_ts",    a_ts,    5);
        check("t1_count", a_count, 1);
        tick();
        check("t1_count0", a_count, 0);
        check("t1_valid0", a_valid, 0);
        check("t1_hold_ts", a_ts, 5);
        check("t1_hold_lv", a_level, 1);

        // 2: toggles while disabled, then re-enable with steady input
        a_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_sample = ~a_sample;
            tick();
        end
        a_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_valid", a_valid, 0);
            check("t2_count", a_count, 0);
        end

        // 3: overflow with reader stalled, then ordered drain
        a_ready = 1'b0;
        for (int i = 0; i < 8; i++) toggle_rec();
        toggle_drop();
        toggle_drop();
        check("t3_count", a_count, 8);
        check("t3_ovf",   a_ovf,   1);
        check("t3_drop",  a_drop,  2);
        tick();
        check("t3_hold_level", a_level, exp_lvl[0]);
        check("t3_hold_ts",    a_ts,    exp_ts[0]);
        drain_check(8);

        // 4: push and pop together while full
        for (int i = 0; i < 8; i++) toggle_rec();
        check("t4_full", a_count, 8);
        a_ready  = 1'b1;
        a_sample = ~a_sample;
        void'(exp_lvl.pop_front());
        void'(exp_ts.pop_front());
        exp_lvl.push_back(int'(a_sample));
        exp_ts.push_back(cyc);
        tick();
        a_ready = 1'b0;
        check("t4_count", a_count, 8);
        check("t4_drop",  a_drop,  2);
        check("t4_ovf",   a_ovf,   1);
        drain_check(8);

        // 5: clear alone, clear racing a drop, saturation
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("t5_clr_ovf",  a_ovf,  0);
        check("t5_clr_drop", a_drop, 0);
        for (int i = 0; i < 8; i++) toggle_rec();
        for (int i = 0; i < 3; i++) toggle_drop();
        check("t5_drop3", a_drop, 3);
        a_clear = 1'b1;
        toggle_drop();
        a_clear = 1'b0;
        check("t5_race_ovf",  a_ovf,  1);
        check("t5_race_drop", a_drop, 1);
        for (int i = 0; i < 300; i++) toggle_drop();
        check("t5_sat", a_drop, 255);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("t5_clr2", a_drop, 0);
        drain_check(8);

        // 6: reset in the middle of a handshake
        for (int i = 0; i < 5; i++) toggle_rec();
        check("t6_count5", a_count, 5);
        a_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("t6_valid", a_valid, 0);
        check("t6_count", a_count, 0);
        check("t6_ts",    a_ts,    0);
        check("t6_level", a_level, 0);
        check("t6_ovf",   a_ovf,   0);
        exp_lvl.delete();
        exp_ts.delete();
        a_ready  = 1'b0;
        a_sample = 1'b0;
        b_sample = 1'b0;
        #10 rst_n = 1'b1;
        wait_cyc(3);
        a_sample = 1'b1;
        tick();
        check("t6_new_valid", a_valid, 1);
        check("t6_new_level", a_level, 1);
        check("t6_new_ts",    a_ts,    3);

        // 7: 4-bit timestamp wrap on instance B
        wait_cyc(14);
        b_sample = 1'b1;
        wait_cyc(18);
        b_sample = 1'b0;
        tick();
        check("t7_count", b_count, 2);
        check("t7_valid", b_valid, 1);
        check("t7_lv0",   b_level, 1);
        check("t7_ts0",   b_ts,    14);
        b_ready = 1'b1;
        tick();
        check("t7_lv1", b_level, 0);
        check("t7_ts1", b_ts,    2);
        tick();
        b_ready = 1'b0;
        check("t7_empty", b_count, 0);
        check("t7_hold",  b_ts,    2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_edge_event_recorder
